// File: rtl/mlp_seq.sv
// Address/handshake sequencer for a two-layer MLP evaluation.
// Walks layer-1 weights, then layer-2 weights, one MAC beat per transfer.
module mlp_seq #(
  parameter int IN_DIM  = 1,
  parameter int L1_DIM  = 1,
  parameter int OUT_DIM = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_idx,
  output logic [ADDR_W-1:0] n_idx,
  output logic              layer,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic              mac_first,
  output logic              mac_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] X_LAST_L1 = ADDR_W'(IN_DIM - 1);
  localparam logic [ADDR_W-1:0] X_LAST_L2 = ADDR_W'(L1_DIM - 1);
  localparam logic [ADDR_W-1:0] N_LAST_L1 = ADDR_W'(L1_DIM - 1);
  localparam logic [ADDR_W-1:0] N_LAST_L2 = ADDR_W'(OUT_DIM - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] x_idx_q, x_idx_d;
  logic [ADDR_W-1:0] n_idx_q, n_idx_d;

  logic [ADDR_W-1:0] x_last;
  logic [ADDR_W-1:0] n_last;
  logic              in_layer;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      w_addr_q <= '0;
      x_idx_q  <= '0;
      n_idx_q  <= '0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      x_idx_q  <= x_idx_d;
      n_idx_q  <= n_idx_d;
    end
  end

  // Weight memory is laid out w1 then w2, row-major per neuron, so the flat
  // address is simply a running count of transfers within one evaluation.
  always_comb begin
    state_d  = state_q;
    w_addr_d = w_addr_q;
    x_idx_d  = x_idx_q;
    n_idx_d  = n_idx_q;

    x_last   = (state_q == S_L2) ? X_LAST_L2 : X_LAST_L1;
    n_last   = (state_q == S_L2) ? N_LAST_L2 : N_LAST_L1;
    in_layer = (state_q == S_L1) || (state_q == S_L2);
    xfer     = in_layer && mac_ready;

    case (state_q)
      S_IDLE: begin
        w_addr_d = '0;
        x_idx_d  = '0;
        n_idx_d  = '0;
        if (start) begin
          state_d = S_L1;
        end
      end
      S_L1, S_L2: begin
        if (xfer) begin
          w_addr_d = w_addr_q + ADDR_W'(1);
          if (x_idx_q == x_last) begin
            x_idx_d = '0;
            if (n_idx_q == n_last) begin
              n_idx_d = '0;
              if (state_q == S_L1) begin
                state_d = S_L2;
              end else begin
                state_d  = S_FIN;
                w_addr_d = '0;
              end
            end else begin
              n_idx_d = n_idx_q + ADDR_W'(1);
            end
          end else begin
            x_idx_d = x_idx_q + ADDR_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d  = S_IDLE;
        w_addr_d = '0;
        x_idx_d  = '0;
        n_idx_d  = '0;
      end
      default: begin
        state_d  = S_IDLE;
        w_addr_d = '0;
        x_idx_d  = '0;
        n_idx_d  = '0;
      end
    endcase
  end

  // Outputs decode only registered state, so they cannot move during a stall.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    mac_valid = in_layer;
    layer     = (state_q == S_L2);
    w_addr    = w_addr_q;
    x_idx     = x_idx_q;
    n_idx     = n_idx_q;
    mac_first = in_layer && (x_idx_q == '0);
    mac_last  = in_layer && (x_idx_q == x_last);
  end

endmodule
